hq2x_scanout: RTL and testbench

- Read-side consumer of the hq2x scaler's output line buffer.
- Generates doubled-resolution display timing (512x480 active) and drives the scaler's 10-bit read address.
- Captures the returned 15-bit pixel, expands it to 24-bit RGB, and emits aligned hsync/vsync/de to the video DAC / scan-converter stage.
- Locks each output frame to the scaler's frame_available indication.

---
 rtl/hq2x_video_pkg.sv | 29 ++
 rtl/hq2x_scanout_if.sv | 18 +
 rtl/video_timing_counter.sv | 73 +++++++
 rtl/hq2x_scanout.sv | 111 +++++++++++
 tb/tb_hq2x_scanout.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hq2x_video_pkg.sv
// Shared timing defaults, scanout FSM states and RGB555 -> RGB888 expansion
// for the hq2x read-side scanout.
package hq2x_video_pkg;

  localparam logic [9:0] DEF_H_ACTIVE = 10'd512;
  localparam logic [9:0] DEF_H_FP     = 10'd16;
  localparam logic [9:0] DEF_H_SYNC   = 10'd64;
  localparam logic [9:0] DEF_H_BP     = 10'd48;
  localparam logic [9:0] DEF_V_ACTIVE = 10'd480;
  localparam logic [9:0] DEF_V_FP     = 10'd10;
  localparam logic [9:0] DEF_V_SYNC   = 10'd2;
  localparam logic [9:0] DEF_V_BP     = 10'd33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } scan_state_e;

  // Replicating the top bits keeps full-scale 5'h1F at 8'hFF.
  function automatic logic [23:0] rgb555_to_888(input logic [14:0] pix);
    logic [4:0] r5, g5, b5;
    r5 = pix[4:0];
    g5 = pix[9:5];
    b5 = pix[14:10];
    return {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/hq2x_scanout_if.sv
// Scaler read port plus video output bundle of the hq2x scanout.
interface hq2x_scanout_if;
  logic        frame_available;
  logic [9:0]  read_x;
  logic [14:0] outpixel;
  logic [7:0]  r, g, b;
  logic        hs, vs, de, locked;

  modport master (
    input  frame_available, outpixel,
    output read_x, r, g, b, hs, vs, de, locked
  );

  modport slave (
    output frame_available, outpixel,
    input  read_x, r, g, b, hs, vs, de, locked
  );
endinterface

// File: rtl/video_timing_counter.sv
// Raster hcnt/vcnt counters advancing on ce_i, with clear-to-origin and hold.
// Decodes active, raw (active-high) sync regions and end-of-frame from the counters.
module video_timing_counter
  import hq2x_video_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
  parameter logic [9:0] H_FP     = DEF_H_FP,
  parameter logic [9:0] H_SYNC   = DEF_H_SYNC,
  parameter logic [9:0] H_BP     = DEF_H_BP,
  parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE,
  parameter logic [9:0] V_FP     = DEF_V_FP,
  parameter logic [9:0] V_SYNC   = DEF_V_SYNC,
  parameter logic [9:0] V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_i,
  input  logic       clear_i,
  input  logic       hold_i,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic       active_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o,
  output logic       end_of_frame_o
);

  localparam logic [9:0] H_LAST   = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
  localparam logic [9:0] V_LAST   = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
  localparam logic [9:0] HS_START = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_END   = HS_START + H_SYNC;
  localparam logic [9:0] VS_START = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_END   = VS_START + V_SYNC;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (ce_i) begin
      if (clear_i) begin
        hcnt_d = '0;
        vcnt_d = '0;
      end else if (!hold_i) begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end else begin
          hcnt_d = hcnt_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o         = hcnt_q;
  assign vcnt_o         = vcnt_q;
  assign active_o       = (hcnt_q < H_ACTIVE) && (vcnt_q < V_ACTIVE);
  assign hs_raw_o       = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vs_raw_o       = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  assign end_of_frame_o = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/hq2x_scanout.sv
// Frame-locked scanout of the hq2x line buffer: drives read_x, expands the returned
// pixel to RGB888 and emits de/hs/vs two clocks behind the raster counters.
module hq2x_scanout
  import hq2x_video_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
  parameter logic [9:0] H_FP     = DEF_H_FP,
  parameter logic [9:0] H_SYNC   = DEF_H_SYNC,
  parameter logic [9:0] H_BP     = DEF_H_BP,
  parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE,
  parameter logic [9:0] V_FP     = DEF_V_FP,
  parameter logic [9:0] V_SYNC   = DEF_V_SYNC,
  parameter logic [9:0] V_BP     = DEF_V_BP
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce_pix,
  hq2x_scanout_if.master vid
);

  scan_state_e state_q, state_d;
  logic        cnt_clear, cnt_hold;
  logic [9:0]  hcnt, vcnt;
  logic        active, hs_raw, vs_raw, end_of_frame;
  logic        run;
  logic        act1_q, hs1_q, vs1_q;
  logic        de_q, hs_q, vs_q;
  logic [23:0] rgb_q;
  logic        unused_cnt_bits;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk           (clk),
    .reset         (reset),
    .ce_i          (ce_pix),
    .clear_i       (cnt_clear),
    .hold_i        (cnt_hold),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .active_o      (active),
    .hs_raw_o      (hs_raw),
    .vs_raw_o      (vs_raw),
    .end_of_frame_o(end_of_frame)
  );

  assign unused_cnt_bits = ^{hcnt[9], vcnt[9:1]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A frame-end wrap only happens with a frame ready; otherwise park at the last pixel.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_hold  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (ce_pix && vid.frame_available) state_d = RUN;
      end
      RUN: begin
        if (end_of_frame && !vid.frame_available) begin
          cnt_hold = 1'b1;
          if (ce_pix) state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_clear = vid.frame_available;
        cnt_hold  = !vid.frame_available;
        if (ce_pix && vid.frame_available) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      de_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rgb_q  <= '0;
    end else begin
      act1_q <= active && run;
      hs1_q  <= !(hs_raw && run);
      vs1_q  <= !(vs_raw && run);
      de_q   <= act1_q;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
      rgb_q  <= act1_q ? rgb555_to_888(vid.outpixel) : 24'h0;
    end
  end

  assign vid.read_x = active ? {vcnt[0], hcnt[8:0]} : 10'd0;
  assign vid.r      = rgb_q[23:16];
  assign vid.g      = rgb_q[15:8];
  assign vid.b      = rgb_q[7:0];
  assign vid.de     = de_q;
  assign vid.hs     = hs_q;
  assign vid.vs     = vs_q;
  assign vid.locked = (state_q != IDLE);

endmodule

// File: tb/tb_hq2x_scanout.sv
// Scoreboard bench for hq2x_scanout with a short vertical raster (8 active lines of 14)
// and the default 640-tick horizontal timing.
module tb_hq2x_scanout;

  localparam int HT     = 640;
  localparam int VT     = 14;
  localparam int FRAME  = HT * VT;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;

  typedef struct {
    int         due;
    logic [7:0] r, g, b;
    logic       de, hs, vs, locked;
    logic [9:0] rx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ce_pix;

  hq2x_scanout_if bus();

  hq2x_scanout #(
    .V_ACTIVE(10'd8), .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce_pix(ce_pix),
    .vid   (bus)
  );

  always #5 clk = ~clk;

  // Scaler patterns by read_x[2:0] with hand-expanded RGB888 results.
  logic [14:0] pix_tab [8] = '{15'h001F, 15'h7FFF, 15'h0210, 15'h4000,
                               15'h0000, 15'h03E0, 15'h7C00, 15'h2108};
  logic [23:0] rgb_tab [8] = '{24'hFF0000, 24'hFFFFFF, 24'h848400, 24'h000084,
                               24'h000000, 24'h00FF00, 24'h0000FF, 24'h424242};

  always @(posedge clk) bus.outpixel <= pix_tab[bus.read_x[2:0]];

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (mon_e.due != cyc || bus.de !== mon_e.de || bus.hs !== mon_e.hs ||
          bus.vs !== mon_e.vs || bus.r !== mon_e.r || bus.g !== mon_e.g ||
          bus.b !== mon_e.b || bus.locked !== mon_e.locked || bus.read_x !== mon_e.rx) begin
        n_err++;
        $display("FAIL outputs cyc=%0d due=%0d: got de=%b hs=%b vs=%b rgb=%h%h%h locked=%b read_x=%0d, want de=%b hs=%b vs=%b rgb=%h%h%h locked=%b read_x=%0d",
                 cyc, mon_e.due, bus.de, bus.hs, bus.vs, bus.r, bus.g, bus.b, bus.locked, bus.read_x,
                 mon_e.de, mon_e.hs, mon_e.vs, mon_e.r, mon_e.g, mon_e.b, mon_e.locked, mon_e.rx);
      end
    end
  end

  logic cnt_en = 1'b0;
  int   de_cnt = 0, hsl_cnt = 0, vsl_cnt = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      if (bus.de === 1'b1) de_cnt++;
      if (bus.hs === 1'b0) hsl_cnt++;
      if (bus.vs === 1'b0) vsl_cnt++;
    end
  end

  task automatic check_cnt(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Reference raster: a linear pixel position within the frame plus lock state.
  task automatic mdl_next(input int st, input int pos, input logic ce, input logic fa,
                          input logic rst, output int nst, output int npos);
    nst  = st;
    npos = pos;
    if (rst) begin
      nst  = M_IDLE;
      npos = 0;
    end else if (ce) begin
      case (st)
        M_IDLE: if (fa) nst = M_RUN;
        M_RUN: begin
          if (pos == FRAME - 1) begin
            if (fa) npos = 0;
            else    nst = M_WAIT;
          end else begin
            npos = pos + 1;
          end
        end
        default: if (fa) begin nst = M_RUN; npos = 0; end
      endcase
    end
  endtask

  function automatic logic [9:0] rx_of(input int pos);
    int h, v;
    h = pos % HT;
    v = pos / HT;
    if (h < 512 && v < 8) return 10'((v % 2) * 512 + h);
    return 10'd0;
  endfunction

  function automatic exp_t mdl_pipe(input int st, input int pos);
    exp_t       e;
    int         h, v;
    logic [9:0] rx;
    h    = pos % HT;
    v    = pos / HT;
    e.de = (st == M_RUN) && h < 512 && v < 8;
    e.hs = !((st == M_RUN) && h >= 528 && h < 592);
    e.vs = !((st == M_RUN) && v >= 10 && v < 12);
    rx   = rx_of(pos);
    {e.r, e.g, e.b} = e.de ? rgb_tab[rx[2:0]] : 24'h0;
    e.due    = 0;
    e.locked = 1'b0;
    e.rx     = 10'd0;
    return e;
  endfunction

  int   st_cur = M_IDLE, pos_cur = 0, st_prev = M_IDLE, pos_prev = 0;
  logic rst_prev = 1'b1;

  task automatic step(input logic ce, input logic fa, input logic rst);
    int   nst, npos;
    exp_t e;
    reset = rst;
    ce_pix = ce;
    bus.frame_available = fa;
    mdl_next(st_cur, pos_cur, ce, fa, rst, nst, npos);
    e = mdl_pipe(st_prev, pos_prev);
    if (rst || rst_prev) begin
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
      e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
    end
    e.locked = (nst != M_IDLE);
    e.rx     = rx_of(npos);
    e.due    = cyc + 1;
    sb.push_back(e);
    st_prev  = st_cur;
    pos_prev = pos_cur;
    st_cur   = nst;
    pos_cur  = npos;
    rst_prev = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ce_pix = 1'b1;
    bus.frame_available = 1'b0;
    @(posedge clk);
    #1;

    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b0);

    // First frame, then park in WAIT with no new frame offered.
    cnt_en = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    repeat (FRAME) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    cnt_en = 1'b0;
    check_cnt("de_cycles_per_frame", de_cnt, 512 * 8);
    check_cnt("hs_low_cycles_per_frame", hsl_cnt, 64 * 14);
    check_cnt("vs_low_cycles_per_frame", vsl_cnt, 2 * 640);

    // Restart from WAIT; frame_available stays high across the frame and its end.
    step(1'b1, 1'b1, 1'b0);
    repeat (FRAME) step(1'b1, 1'b1, 1'b0);

    // Sparse ce_pix, then a mid-line reset that collides with ce_pix and frame_available.
    for (int i = 0; i < 4 * (5 * HT + 100); i++) step(i % 4 == 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(i % 4 == 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4 * 2 * HT; i++) step(i % 4 == 0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check_cnt("scoreboard_left_unchecked", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
